// File: rtl/bs_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bs_arbiter: round-robin front end sharing one binary-search engine         |
// | Optional watchdog/recover path: define BS_ARB_TIMEOUT_EN.      Rev 1.0     |
// +----------------------------------------------------------------------------+
module bs_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 8,
  parameter int LOC_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_key,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic                   resp_found,
  output logic [LOC_W-1:0]       resp_loc,
  output logic                   resp_timeout,
  output logic [DATA_W-1:0]      eng_A,
  output logic                   eng_Start,
  output logic                   eng_Reset,
  input  logic                   eng_Done,
  input  logic                   eng_Found,
  input  logic [LOC_W-1:0]       eng_Loc
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_RESP    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic [IDX_W-1:0]  w_cand;
  logic              w_any;
  logic [DATA_W-1:0] r_eng_a;
  logic              r_found;
  logic [LOC_W-1:0]  r_loc;

  // Scan from last_owner+NREQ down to last_owner+1; the final hit wins, so the
  // requester right after the previous owner has top priority.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(r_last) + k) % NREQ);
      if (req_valid[w_cand]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && !Reset && w_any) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (r_state == S_RESP) begin
      resp_valid[r_owner] = 1'b1;
    end
  end

`ifdef BS_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_rcnt;
  logic            r_tmo;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_wdog <= '0;
      r_rcnt <= 1'b0;
    end else begin
      r_wdog <= (r_state == S_SEARCH) ? r_wdog + 1'b1 : '0;
      r_rcnt <= (r_state == S_RECOVER) ? ~r_rcnt : 1'b0;
    end
  end

  assign resp_timeout = r_tmo;
`else
  localparam int c_unused_timeout = TIMEOUT;

  assign resp_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_SEARCH;
      end
      S_SEARCH: begin
        if (eng_Done) begin
          w_next = S_RESP;
`ifdef BS_ARB_TIMEOUT_EN
        end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
          w_next = S_RECOVER;
`endif
        end
      end
      S_RESP: begin
        if (resp_ready[r_owner] && !eng_Done) w_next = S_IDLE;
      end
      S_RECOVER: begin
`ifdef BS_ARB_TIMEOUT_EN
        if (r_rcnt) w_next = S_RESP;
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(NREQ - 1);
      r_eng_a <= '0;
      r_found <= 1'b0;
      r_loc   <= '0;
`ifdef BS_ARB_TIMEOUT_EN
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_gnt_idx;
            r_last  <= w_gnt_idx;
            r_eng_a <= req_key[int'(w_gnt_idx)*DATA_W +: DATA_W];
          end
        end
        S_SEARCH: begin
          if (eng_Done) begin
            r_found <= eng_Found;
            r_loc   <= eng_Found ? eng_Loc : '0;
`ifdef BS_ARB_TIMEOUT_EN
            r_tmo   <= 1'b0;
`endif
          end
        end
`ifdef BS_ARB_TIMEOUT_EN
        S_RECOVER: begin
          r_found <= 1'b0;
          r_loc   <= '0;
          r_tmo   <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign eng_A      = r_eng_a;
  assign eng_Start  = (r_state == S_SEARCH);
  assign eng_Reset  = Reset | (r_state == S_RECOVER);
  assign resp_found = r_found;
  assign resp_loc   = r_loc;

endmodule
`default_nettype wire

// File: tb/tb_bs_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bs_arbiter: scoreboard bench for bs_arbiter with a behavioural engine   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_bs_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
  localparam int LOC_W  = 5;

  logic                   clk = 1'b0;
  logic                   Reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_key;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic                   resp_found;
  logic [LOC_W-1:0]       resp_loc;
  logic                   resp_timeout;
  logic [DATA_W-1:0]      eng_A;
  logic                   eng_Start;
  logic                   eng_Reset;
  logic                   eng_Done = 1'b0;
  logic                   eng_Found = 1'b0;
  logic [LOC_W-1:0]       eng_Loc = '0;

  bs_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .LOC_W(LOC_W), .TIMEOUT(64)) dut (
    .clk(clk), .Reset(Reset),
    .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_found(resp_found), .resp_loc(resp_loc), .resp_timeout(resp_timeout),
    .eng_A(eng_A), .eng_Start(eng_Start), .eng_Reset(eng_Reset),
    .eng_Done(eng_Done), .eng_Found(eng_Found), .eng_Loc(eng_Loc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mask;
    logic [7:0] key;
  } gnt_t;

  typedef struct packed {
    logic [3:0] mask;
    logic       found;
    logic [4:0] loc;
    logic       tmo;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  gnt_t g_exp;
  rsp_t r_exp;

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_grants = 0;

  int         eng_delay   = 5;
  logic       eng_found_v = 1'b1;
  logic [4:0] eng_loc_v   = '0;
  int         ecnt        = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine model: Done pulses once, eng_delay cycles after Start; 0 = never.
  always @(posedge clk) begin
    if (eng_Reset || !eng_Start) begin
      ecnt     <= 0;
      eng_Done <= 1'b0;
    end else begin
      ecnt      <= ecnt + 1;
      eng_Done  <= (eng_delay != 0) && (ecnt + 1 == eng_delay);
      eng_Found <= eng_found_v;
      eng_Loc   <= eng_loc_v;
    end
  end

  logic       busy     = 1'b0;
  logic       prev_rv  = 1'b0;
  logic       chk_next = 1'b0;
  logic [7:0] nk       = '0;

  always @(negedge clk) begin
    if (Reset) begin
      busy     = 1'b0;
      prev_rv  = 1'b0;
      chk_next = 1'b0;
    end else begin
      if (chk_next) begin
        chk("eng_Start_after_grant", 32'(eng_Start), 32'd1);
        chk("eng_A", 32'(eng_A), 32'(nk));
        chk_next = 1'b0;
      end
      if (req_ready != 0) begin
        chk("grant_while_busy", 32'(busy), 32'd0);
        if (gq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_grant: got %b expected none", req_ready);
        end else begin
          g_exp = gq.pop_front();
          chk("grant_mask", 32'(req_ready), 32'(g_exp.mask));
          nk       = g_exp.key;
          chk_next = 1'b1;
        end
        busy = 1'b1;
        n_grants++;
      end
      if (resp_valid != 0 && !prev_rv) begin
        if (rq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp: got %b expected none", resp_valid);
        end else begin
          r_exp = rq.pop_front();
          chk("resp_mask", 32'(resp_valid), 32'(r_exp.mask));
          chk("resp_found", 32'(resp_found), 32'(r_exp.found));
          chk("resp_loc", 32'(resp_loc), 32'(r_exp.loc));
          chk("resp_timeout", 32'(resp_timeout), 32'(r_exp.tmo));
        end
      end
      if ((resp_valid & resp_ready) != 0 && !eng_Done) busy = 1'b0;
      prev_rv = (resp_valid != 0);
    end
  end

  task automatic set_key(input int idx, input logic [7:0] k);
    req_key[idx*DATA_W +: DATA_W] = k;
  endtask

  task automatic wait_grant(input int idx);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_wait_%0d: got no grant expected grant within 300 cycles", idx);
    end
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rq.size() == 0 && resp_valid == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0 within 1000 cycles", rq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by 500us");
    $fatal(1);
  end

  initial begin
    int g0;
    bit ok;
    Reset      = 1'b1;
    req_key    = '0;
    resp_ready = '1;
    req_valid  = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_found", 32'(resp_found), 32'd0);
    chk("rst_resp_loc", 32'(resp_loc), 32'd0);
    chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
    chk("rst_eng_Start", 32'(eng_Start), 32'd0);
    chk("rst_eng_A", 32'(eng_A), 32'd0);
    chk("rst_eng_Reset", 32'(eng_Reset), 32'd1);
    req_valid = '0;
    @(posedge clk);
    #1;
    Reset = 1'b0;

    // Single request from requester 1, found at 5.
    @(posedge clk);
    #1;
    eng_delay = 10; eng_found_v = 1'b1; eng_loc_v = 5'd5;
    set_key(1, 8'h2A);
    gq.push_back('{4'b0010, 8'h2A});
    rq.push_back('{4'b0010, 1'b1, 5'd5, 1'b0});
    req_valid[1] = 1'b1;
    wait_grant(1);
    wait_drain();

    // Not found: location must read 0.
    eng_delay = 4; eng_found_v = 1'b0; eng_loc_v = 5'd7;
    set_key(2, 8'h77);
    gq.push_back('{4'b0100, 8'h77});
    rq.push_back('{4'b0100, 1'b0, 5'd0, 1'b0});
    req_valid[2] = 1'b1;
    wait_grant(2);
    wait_drain();

    // Backpressure with only non-owner resp_ready bits set.
    eng_delay = 2; eng_found_v = 1'b1; eng_loc_v = 5'd9;
    resp_ready = 4'b0111;
    set_key(3, 8'hC3);
    gq.push_back('{4'b1000, 8'hC3});
    rq.push_back('{4'b1000, 1'b1, 5'd9, 1'b0});
    gq.push_back('{4'b0001, 8'h10});
    rq.push_back('{4'b0001, 1'b1, 5'd9, 1'b0});
    req_valid[3] = 1'b1;
    wait_grant(3);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp_valid != 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_resp_arrived", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    set_key(0, 8'h10);
    req_valid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'b1000);
      chk("bp_found", 32'(resp_found), 32'd1);
      chk("bp_loc", 32'(resp_loc), 32'd9);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = '1;
    wait_grant(0);
    wait_drain();

    // Reset three cycles into SEARCH: no response, requester 0 wins afterwards.
    eng_delay = 50;
    set_key(2, 8'h5C);
    gq.push_back('{4'b0100, 8'h5C});
    req_valid[2] = 1'b1;
    wait_grant(2);
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("midrst_eng_Start", 32'(eng_Start), 32'd0);
    chk("midrst_eng_Reset", 32'(eng_Reset), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;

    // Contention: all four held, grants 0,1,2,3,0.
    eng_delay = 3; eng_found_v = 1'b1; eng_loc_v = 5'd3;
    set_key(0, 8'h11); set_key(1, 8'h22); set_key(2, 8'h33); set_key(3, 8'h44);
    gq.push_back('{4'b0001, 8'h11}); rq.push_back('{4'b0001, 1'b1, 5'd3, 1'b0});
    gq.push_back('{4'b0010, 8'h22}); rq.push_back('{4'b0010, 1'b1, 5'd3, 1'b0});
    gq.push_back('{4'b0100, 8'h33}); rq.push_back('{4'b0100, 1'b1, 5'd3, 1'b0});
    gq.push_back('{4'b1000, 8'h44}); rq.push_back('{4'b1000, 1'b1, 5'd3, 1'b0});
    gq.push_back('{4'b0001, 8'h11}); rq.push_back('{4'b0001, 1'b1, 5'd3, 1'b0});
    g0 = n_grants;
    req_valid = 4'b1111;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_grants >= g0 + 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("contention_grants", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain();

`ifdef BS_ARB_TIMEOUT_EN
    begin
      int ns;
      int nr;
      eng_delay = 0;
      set_key(1, 8'h5A);
      gq.push_back('{4'b0010, 8'h5A});
      rq.push_back('{4'b0010, 1'b0, 5'd0, 1'b1});
      req_valid[1] = 1'b1;
      wait_grant(1);
      ns = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (eng_Reset) break;
        if (eng_Start) ns++;
      end
      nr = 0;
      for (int i = 0; i < 10 && eng_Reset; i++) begin
        nr++;
        @(negedge clk);
      end
      chk("wd_search_cycles", 32'(ns), 32'd64);
      chk("wd_recover_cycles", 32'(nr), 32'd2);
      wait_drain();
    end
`endif

    repeat (5) @(posedge clk);
    chk("gq_empty", 32'(gq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
